prll_bus_rr_sched: RTL and testbench

Round-robin scheduler that shares one parallel bus among `DRVRS` driver FIFOs. It picks one pending driver, pops one packet from it, and decodes the packet's target field. It then pushes the packet to the target driver, or to every driver except the source on broadcast. It is the arbitration/sequencing core of the parallel bus system and replaces ad-hoc fixed-priority selection with fair, starvation-free access.

---
 rtl/prll_bus_pkg.sv | 29 ++
 rtl/prll_bus_rr_sched_picker.sv | 35 +++
 rtl/prll_bus_rr_sched.sv | 148 ++++++++++++++
 tb/tb_prll_bus_rr_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prll_bus_pkg.sv
// Shared definitions for the parallel-bus round-robin scheduler.
// Packet layout: [BITS-1 -: 8] target, next 8 bits source, rest payload/ID.
package prll_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_DELIVER
  } sched_state_t;

  // Field offsets counted down from the packet MSB, so they hold for any BITS.
  localparam int unsigned TGT_MSB = 0;
  localparam int unsigned TGT_LSB = 7;
  localparam int unsigned SRC_MSB = 8;
  localparam int unsigned SRC_LSB = 15;
  localparam int unsigned FLD_W   = TGT_LSB - TGT_MSB + 1;

  localparam logic [7:0] BROADCAST_ID = 8'hFF;

  // Widest packet the helper accepts; callers zero-extend into this width.
  localparam int unsigned PKT_MAX = 256;

  // Target field of a packet that is `bits` wide.
  function automatic logic [FLD_W-1:0] tgt_of(input logic [PKT_MAX-1:0] pkt,
                                               input int unsigned bits);
    return pkt[bits-1-TGT_MSB -: FLD_W];
  endfunction

endpackage

// File: rtl/prll_bus_rr_sched_picker.sv
// rr_prio_picker: combinational round-robin picker. Returns the first set
// request at or after ptr, searching upward with wrap-around.
module rr_prio_picker #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  ofs;
  logic [IW:0]    sum;

  // Double the vector, rotate so ptr sits at bit 0, take lowest set bit.
  always_comb begin
    dbl = {req, req};
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = dbl[32'(ptr) + i];
    end
    ofs = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) ofs = IW'(i - 1);
    end
    sum = {1'b0, ptr} + {1'b0, ofs};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    gnt_idx = sum[IW-1:0];
    any     = |req;
  end

endmodule

// File: rtl/prll_bus_rr_sched.sv
// prll_bus_rr_sched: round-robin scheduler sharing one parallel bus among
// DRVRS driver FIFOs. IDLE picks a pending driver, POP pops its head packet,
// DELIVER pushes it to the target driver (or all but the source on broadcast).
// Optional feature macro: PRLL_SCHED_STATS_EN adds drop_cnt and grant counters.
module prll_bus_rr_sched
  import prll_bus_pkg::*;
#(
  parameter int unsigned BITS      = 32,
  parameter int unsigned DRVRS     = 2,
  parameter logic [7:0]  BROADCAST = BROADCAST_ID
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DRVRS-1:0]      pndng,
  input  logic [DRVRS*BITS-1:0] D_pop,
  output logic [DRVRS-1:0]      pop,
  output logic [DRVRS-1:0]      push,
  output logic [BITS-1:0]       D_push,
  output logic                  busy
`ifdef PRLL_SCHED_STATS_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int unsigned IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  sched_state_t      state, state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     winner;
  logic [BITS-1:0]   pkt;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [BITS-1:0]   head;
  logic              head_pend;
  logic [FLD_W-1:0]  tgt;
  logic [DRVRS-1:0]  route_mask;
  logic              route_drop;

  rr_prio_picker #(.N(DRVRS)) u_pick (
    .req     (pndng),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Head packet and pending flag of the granted driver.
  always_comb begin
    head      = '0;
    head_pend = 1'b0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (winner == IW'(i)) begin
        head      = D_pop[i*BITS +: BITS];
        head_pend = pndng[i];
      end
    end
  end

  // Receiver mask from the target field; broadcast excludes the granted index.
  always_comb begin
    tgt        = tgt_of(PKT_MAX'(pkt), BITS);
    route_mask = '0;
    route_drop = 1'b0;
    if (32'(tgt) < DRVRS) begin
      route_mask = {{(DRVRS-1){1'b0}}, 1'b1} << tgt;
    end else if (tgt == BROADCAST) begin
      route_mask         = '1;
      route_mask[winner] = 1'b0;
    end else begin
      route_drop = 1'b1;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    pop       = '0;
    push      = '0;
    case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = ST_POP;
      end
      ST_POP: begin
        if (head_pend) begin
          pop[winner] = 1'b1;
          state_nxt   = ST_DELIVER;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DELIVER: begin
        push      = route_mask;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Grant, packet latch and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner <= '0;
      pkt    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE:    if (pick_any) winner <= pick_idx;
        ST_POP:     if (head_pend) pkt <= head;
        ST_DELIVER: rr_ptr <= (winner == IW'(DRVRS - 1)) ? '0 : winner + IW'(1);
        default:    ;
      endcase
    end
  end

  assign D_push = pkt;
  assign busy   = (state != ST_IDLE);

`ifdef PRLL_SCHED_STATS_EN
  logic [15:0] grant_cnt [DRVRS];

  // Saturating count of packets dropped for an unroutable target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (state == ST_DELIVER && route_drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Saturating per-driver grant counters, bumped on each pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DRVRS; i++) grant_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DRVRS; i++) begin
        if (pop[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prll_bus_rr_sched.sv
// Scoreboard bench for prll_bus_rr_sched (DRVRS=4). Driver FIFOs are queues in
// the bench; a reference model predicts grants and deliveries from the
// round-robin rules, a monitor compares every push against the scoreboard.
module tb_prll_bus_rr_sched;
  localparam int unsigned BITS = 32;
  localparam int unsigned D    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [D-1:0]    pndng;
  logic [D*BITS-1:0] D_pop;
  logic [D-1:0]    pop, push;
  logic [BITS-1:0] D_push;
  logic            busy;
`ifdef PRLL_SCHED_STATS_EN
  logic [15:0]     drop_cnt;
`endif

  always #5 clk = ~clk;

  prll_bus_rr_sched #(.BITS(BITS), .DRVRS(D), .BROADCAST(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy)
`ifdef PRLL_SCHED_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  typedef struct {
    logic [D-1:0]    mask;
    logic [BITS-1:0] data;
  } exp_t;

  int unsigned     n_chk = 0;
  int unsigned     n_pass = 0;
  logic [BITS-1:0] drvq [D][$];
  exp_t            expq [$];
  int              cyc = 0;
  int              pop_cycle = -1;
  int              deliver_cycle = -1;
  int              next_decide = 0;
  int unsigned     ptr = 0;
  int unsigned     w_pred = 0;
  int              pop_pending = -1;
  int unsigned     drop_model = 0;
  bit              deliver_drop = 1'b0;
  bit              gen_en = 1'b0;
  logic [D-1:0]    dropout = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int unsigned rr_first(input logic [D-1:0] req, input int unsigned p);
    for (int unsigned k = 0; k < D; k++) begin
      if (req[(p + k) % D]) return (p + k) % D;
    end
    return 0;
  endfunction

  function automatic logic [D-1:0] route(input logic [BITS-1:0] pk, input int unsigned src);
    int unsigned t;
    logic [D-1:0] m;
    t = int'(pk[31:24]);
    if (t < D) return D'(1) << t;
    if (t == 255) begin
      m = '1;
      m[src] = 1'b0;
      return m;
    end
    return '0;
  endfunction

  function automatic logic [BITS-1:0] gen_pkt(input int unsigned src);
    int unsigned r;
    logic [7:0] t;
    r = $urandom_range(0, 9);
    if (r < 5)      t = 8'($urandom_range(0, D - 1));
    else if (r < 7) t = 8'hFF;
    else if (r < 8) t = 8'(src);
    else            t = 8'($urandom_range(D, 254));
    return {t, 8'(src), 16'($urandom)};
  endfunction

  task automatic drive();
    for (int unsigned i = 0; i < D; i++) begin
      pndng[i] = (drvq[i].size() > 0) && !dropout[i];
      D_pop[i*BITS +: BITS] = (drvq[i].size() > 0) ? drvq[i][0] : '0;
    end
  endtask

  // One clock: apply the FIFO pop seen last cycle, new arrivals, new inputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pending >= 0) begin
      void'(drvq[pop_pending].pop_front());
      pop_pending = -1;
    end
    dropout = '0;
    if (gen_en) begin
      for (int unsigned i = 0; i < D; i++) begin
        if ($urandom_range(0, 99) < 30 && drvq[i].size() < 4) drvq[i].push_back(gen_pkt(i));
        if ($urandom_range(0, 7) == 0) dropout[i] = 1'b1;
      end
    end
    drive();
  endtask

  // Reference model: grant prediction and expected deliveries.
  initial begin : model
    logic [D-1:0]    exp_pop;
    logic [D-1:0]    m;
    logic [BITS-1:0] pk;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        pop_cycle     = -1;
        deliver_cycle = -1;
        next_decide   = cyc + 1;
        ptr           = 0;
        drop_model    = 0;
        deliver_drop  = 1'b0;
        expq.delete();
        continue;
      end
      exp_pop = '0;
      if (cyc == pop_cycle) begin
        if (pndng[w_pred]) begin
          exp_pop[w_pred] = 1'b1;
          pk = drvq[w_pred][0];
          m  = route(pk, w_pred);
          if (m != '0) expq.push_back('{m, pk});
          else deliver_drop = 1'b1;
          deliver_cycle = cyc + 1;
          next_decide   = cyc + 2;
          ptr           = (w_pred + 1) % D;
          pop_pending   = int'(w_pred);
        end else begin
          next_decide = cyc + 1;
        end
      end
      chk("pop", 32'(pop), 32'(exp_pop));
`ifdef PRLL_SCHED_STATS_EN
      chk("drop_cnt", 32'(drop_cnt), drop_model);
`endif
      if (cyc == deliver_cycle && deliver_drop) begin
        chk("push_on_drop", 32'(push), 32'd0);
        drop_model++;
        deliver_drop = 1'b0;
      end
      if (cyc == next_decide) begin
        if (|pndng) begin
          w_pred    = rr_first(pndng, ptr);
          pop_cycle = cyc + 1;
        end else begin
          next_decide = cyc + 1;
        end
      end
    end
  end

  // Monitor: every push is popped from the scoreboard and compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && push != '0) begin
        chk("pop_push_excl", 32'(pop), 32'd0);
        if (expq.size() == 0) begin
          chk("push_unexpected", 32'(push), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("push_mask", 32'(push), 32'(e.mask));
          chk("D_push", D_push, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    bit found;
    reset = 1'b0;
    pndng = '0;
    D_pop = '0;
    repeat (3) step();
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_D_push", D_push, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef PRLL_SCHED_STATS_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    // Single packet from driver 0 to driver 1, released mid-cycle.
    drvq[0].push_back(32'h01_00_0005);
    drive();
    #2 reset = 1'b1;
    repeat (8) step();
    // Broadcast from driver 2, then an unroutable target from driver 1.
    drvq[2].push_back({8'hFF, 8'h02, 16'h1234});
    repeat (6) step();
    drvq[1].push_back({8'h07, 8'h01, 16'h00AA});
    repeat (6) step();
    // All drivers continuously pending: strict rotation.
    for (int unsigned i = 0; i < D; i++) begin
      drvq[i].push_back({8'((i + 1) % D), 8'(i), 16'(16'h100 + i)});
      drvq[i].push_back({8'hFF, 8'(i), 16'(16'h200 + i)});
    end
    repeat (30) step();
    // Random traffic with occasional pending dropouts.
    gen_en = 1'b1;
    repeat (600) step();
    gen_en = 1'b0;
    repeat (80) step();
    // Reset asserted during DELIVER of a driver-0 packet.
    drvq[0].push_back({8'h02, 8'h00, 16'hBEEF});
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cyc + 1 == deliver_cycle) begin
        found = 1'b1;
        break;
      end
    end
    chk("deliver_seen", 32'(found), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_push", 32'(push), 32'd0);
    chk("arst_pop", 32'(pop), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_D_push", D_push, 32'd0);
    // Fresh requests on drivers 0 and 1: pointer restarts at 0.
    drvq[0].push_back({8'h01, 8'h00, 16'h0C01});
    drvq[1].push_back({8'h00, 8'h01, 16'h0C02});
    step();
    step();
    #2 reset = 1'b1;
    repeat (20) step();
    chk("sb_empty", expq.size(), 32'd0);
    for (int unsigned i = 0; i < D; i++) chk("drvq_empty", drvq[i].size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
